// File: rtl/count_seq_ctrl.sv
// Sequencer for a 4-bit loadable up-counter. Each run sweeps the counter from a
// latched start value to all-ones for a latched number of passes. Each counter
// value is offered downstream as one item over a valid/ready handshake.
module count_seq_ctrl #(
  parameter int CNT_W  = 4,
  parameter int PASS_W = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [CNT_W-1:0]  init_val,
  input  logic [PASS_W-1:0] num_passes,
  input  logic              cnt_cout,
  output logic              cnt_ld,
  output logic              cnt_en,
  output logic [CNT_W-1:0]  cnt_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [PASS_W-1:0] out_pass,
  output logic              out_last,
  output logic              busy,
  output logic              done
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_RUN  = 2'd2,
    ST_DONE = 2'd3
  } state_t;

  localparam logic [PASS_W-1:0] PASS_ONE = {{(PASS_W-1){1'b0}}, 1'b1};

  state_t            state_q, state_d;
  logic [CNT_W-1:0]  init_q, init_d;
  logic [PASS_W-1:0] passes_q, passes_d;
  logic [PASS_W-1:0] pass_q, pass_d;

  logic accept;
  logic final_pass;

  // passes_q is never 0 once latched, so passes_q - 1 cannot underflow in RUN.
  assign final_pass = (pass_q == (passes_q - PASS_ONE));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      init_q   <= '0;
      passes_q <= '0;
      pass_q   <= '0;
    end else begin
      state_q  <= state_d;
      init_q   <= init_d;
      passes_q <= passes_d;
      pass_q   <= pass_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    init_d    = init_q;
    passes_d  = passes_q;
    pass_d    = pass_q;
    cnt_ld    = 1'b0;
    cnt_en    = 1'b0;
    out_valid = 1'b0;
    out_last  = 1'b0;
    busy      = 1'b1;
    done      = 1'b0;
    accept    = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        busy = 1'b0;
        if (start) begin
          init_d   = init_val;
          passes_d = (num_passes == '0) ? PASS_ONE : num_passes;
          pass_d   = '0;
          state_d  = ST_LOAD;
        end
      end

      ST_LOAD: begin
        cnt_ld  = 1'b1;
        state_d = ST_RUN;
      end

      ST_RUN: begin
        out_valid = 1'b1;
        out_last  = cnt_cout && final_pass;
        accept    = out_ready;
        // Increment only below all-ones so the counter never wraps to 0.
        cnt_en    = accept && !cnt_cout;
        if (accept && cnt_cout) begin
          if (final_pass) begin
            state_d = ST_DONE;
          end else begin
            pass_d  = pass_q + PASS_ONE;
            state_d = ST_LOAD;
          end
        end
      end

      ST_DONE: begin
        done    = 1'b1;
        state_d = ST_IDLE;
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  assign cnt_data = init_q;
  assign out_pass = pass_q;

endmodule

// File: tb/tb_count_seq_ctrl.sv
// Directed bench for count_seq_ctrl with a behavioural 4-bit loadable counter
// closing the cnt_ld/cnt_en/cnt_cout loop.
module tb_count_seq_ctrl;

  logic       clk;
  logic       rst;
  logic       start;
  logic [3:0] init_val;
  logic [3:0] num_passes;
  logic       cnt_cout;
  logic       cnt_ld;
  logic       cnt_en;
  logic [3:0] cnt_data;
  logic       out_valid;
  logic       out_ready;
  logic [3:0] out_pass;
  logic       out_last;
  logic       busy;
  logic       done;

  logic [3:0] cnt_q;

  int n_checks;
  int n_fail;

  // Per-cycle expectation tables: st 0=IDLE 1=LOAD 2=RUN 3=DONE.
  logic [1:0] e_st   [16];
  logic [3:0] e_cnt  [16];
  logic [3:0] e_pass [16];
  logic       e_last [16];
  logic       e_en   [16];
  logic       v_rdy  [16];
  logic       v_strt [16];
  logic [3:0] e_data;

  count_seq_ctrl #(.CNT_W(4), .PASS_W(4)) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .init_val   (init_val),
    .num_passes (num_passes),
    .cnt_cout   (cnt_cout),
    .cnt_ld     (cnt_ld),
    .cnt_en     (cnt_en),
    .cnt_data   (cnt_data),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_pass   (out_pass),
    .out_last   (out_last),
    .busy       (busy),
    .done       (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)         cnt_q <= 4'd0;
    else if (cnt_ld) cnt_q <= cnt_data;
    else if (cnt_en) cnt_q <= cnt_q + 4'd1;
  end
  assign cnt_cout = (cnt_q == 4'hF);

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic vec(input int i, input logic [1:0] st, input logic [3:0] cv,
                     input logic [3:0] ps, input logic lst, input logic en,
                     input logic rdy, input logic stt);
    e_st[i] = st; e_cnt[i] = cv; e_pass[i] = ps; e_last[i] = lst;
    e_en[i] = en; v_rdy[i] = rdy; v_strt[i] = stt;
  endtask

  task automatic launch(input logic [3:0] iv, input logic [3:0] np);
    @(negedge clk);
    start = 1'b1; init_val = iv; num_passes = np;
  endtask

  // Walks n cycles, starting with the cycle after the start edge.
  task automatic scan(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      out_ready = v_rdy[i];
      start     = v_strt[i];
      if (v_strt[i]) begin
        init_val = 4'd3; num_passes = 4'd7;
      end
      #1;
      check($sformatf("c%0d ld", i),    cnt_ld,    e_st[i] == 2'd1);
      check($sformatf("c%0d valid", i), out_valid, e_st[i] == 2'd2);
      check($sformatf("c%0d done", i),  done,      e_st[i] == 2'd3);
      check($sformatf("c%0d busy", i),  busy,      e_st[i] != 2'd0);
      check($sformatf("c%0d ld_en", i), cnt_ld && cnt_en, 0);
      check($sformatf("c%0d en_cout", i), cnt_en && cnt_cout, 0);
      if (e_st[i] == 2'd1) check($sformatf("c%0d data", i), cnt_data, e_data);
      if (e_st[i] == 2'd2) begin
        check($sformatf("c%0d cnt", i),  cnt_q,    e_cnt[i]);
        check($sformatf("c%0d pass", i), out_pass, e_pass[i]);
        check($sformatf("c%0d last", i), out_last, e_last[i]);
        check($sformatf("c%0d en", i),   cnt_en,   e_en[i]);
      end
    end
  endtask

  initial begin
    n_checks = 0; n_fail = 0;
    rst = 1'b1; start = 1'b0; init_val = 4'd0; num_passes = 4'd0; out_ready = 1'b0;
    e_data = 4'd0;
    for (int i = 0; i < 16; i++) vec(i, 2'd0, 4'd0, 4'd0, 1'b0, 1'b0, 1'b1, 1'b0);

    @(negedge clk); #1;
    check("rst valid", out_valid, 0);
    check("rst busy",  busy, 0);
    check("rst ld",    cnt_ld, 0);
    check("rst data",  cnt_data, 0);
    check("rst pass",  out_pass, 0);
    check("rst done",  done, 0);
    rst = 1'b0;

    // Two passes from 12, with a stray start and new parameters mid-run.
    e_data = 4'd12;
    vec(0,  2'd1, 4'd0,  4'd0, 1'b0, 1'b0, 1'b1, 1'b0);
    vec(1,  2'd2, 4'd12, 4'd0, 1'b0, 1'b1, 1'b1, 1'b0);
    vec(2,  2'd2, 4'd13, 4'd0, 1'b0, 1'b1, 1'b1, 1'b1);
    vec(3,  2'd2, 4'd14, 4'd0, 1'b0, 1'b1, 1'b1, 1'b0);
    vec(4,  2'd2, 4'd15, 4'd0, 1'b0, 1'b0, 1'b1, 1'b0);
    vec(5,  2'd1, 4'd0,  4'd1, 1'b0, 1'b0, 1'b1, 1'b0);
    vec(6,  2'd2, 4'd12, 4'd1, 1'b0, 1'b1, 1'b1, 1'b0);
    vec(7,  2'd2, 4'd13, 4'd1, 1'b0, 1'b1, 1'b1, 1'b0);
    vec(8,  2'd2, 4'd14, 4'd1, 1'b0, 1'b1, 1'b1, 1'b0);
    vec(9,  2'd2, 4'd15, 4'd1, 1'b1, 1'b0, 1'b1, 1'b0);
    vec(10, 2'd3, 4'd0,  4'd0, 1'b0, 1'b0, 1'b1, 1'b0);
    vec(11, 2'd0, 4'd0,  4'd0, 1'b0, 1'b0, 1'b1, 1'b0);
    launch(4'd12, 4'd2);
    scan(12);

    // Start at 15 with zero passes, start held during DONE.
    e_data = 4'd15;
    vec(0, 2'd1, 4'd0,  4'd0, 1'b0, 1'b0, 1'b1, 1'b0);
    vec(1, 2'd2, 4'd15, 4'd0, 1'b1, 1'b0, 1'b1, 1'b0);
    vec(2, 2'd3, 4'd0,  4'd0, 1'b0, 1'b0, 1'b1, 1'b1);
    vec(3, 2'd0, 4'd0,  4'd0, 1'b0, 1'b0, 1'b1, 1'b0);
    vec(4, 2'd0, 4'd0,  4'd0, 1'b0, 1'b0, 1'b1, 1'b0);
    launch(4'd15, 4'd0);
    scan(5);

    // Backpressure on the first item of a single pass from 14.
    e_data = 4'd14;
    vec(0, 2'd1, 4'd0,  4'd0, 1'b0, 1'b0, 1'b1, 1'b0);
    vec(1, 2'd2, 4'd14, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    vec(2, 2'd2, 4'd14, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    vec(3, 2'd2, 4'd14, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    vec(4, 2'd2, 4'd14, 4'd0, 1'b0, 1'b1, 1'b1, 1'b0);
    vec(5, 2'd2, 4'd15, 4'd0, 1'b1, 1'b0, 1'b1, 1'b0);
    vec(6, 2'd3, 4'd0,  4'd0, 1'b0, 1'b0, 1'b1, 1'b0);
    vec(7, 2'd0, 4'd0,  4'd0, 1'b0, 1'b0, 1'b1, 1'b0);
    launch(4'd14, 4'd1);
    scan(8);

    // Reset in the middle of a run.
    e_data = 4'd10;
    vec(0, 2'd1, 4'd0,  4'd0, 1'b0, 1'b0, 1'b1, 1'b0);
    vec(1, 2'd2, 4'd10, 4'd0, 1'b0, 1'b1, 1'b1, 1'b0);
    vec(2, 2'd2, 4'd11, 4'd0, 1'b0, 1'b1, 1'b1, 1'b0);
    launch(4'd10, 4'd3);
    scan(3);
    #1 rst = 1'b1;
    #1;
    check("mid rst valid", out_valid, 0);
    check("mid rst busy",  busy, 0);
    check("mid rst en",    cnt_en, 0);
    check("mid rst data",  cnt_data, 0);
    check("mid rst done",  done, 0);
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk); #1;
      check($sformatf("post rst done %0d", i), done, 0);
      check($sformatf("post rst busy %0d", i), busy, 0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
